// File: rtl/pacman_input_pkg.sv
// Shared PS/2 scan codes, decoder FSM states and direction encoding for the
// pacman input path, plus small key-map helper functions.
package pacman_input_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_e;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_RIGHT = 2'd1;
    localparam dir_t DIR_DOWN  = 2'd2;
    localparam dir_t DIR_LEFT  = 2'd3;

    typedef struct packed {
        logic hit;
        dir_t dir;
    } key_map_t;

    // One-hot bit order matches the output ports: up, right, down, left.
    function automatic logic [3:0] dir_onehot(input dir_t d);
        logic [3:0] oh;
        case (d)
            DIR_UP:    oh = 4'b0001;
            DIR_RIGHT: oh = 4'b0010;
            DIR_DOWN:  oh = 4'b0100;
            DIR_LEFT:  oh = 4'b1000;
            default:   oh = 4'b0000;
        endcase
        return oh;
    endfunction

    function automatic key_map_t decode_wasd(input logic [7:0] code);
        key_map_t m;
        case (code)
            SC_W:    m = '{hit: 1'b1, dir: DIR_UP};
            SC_D:    m = '{hit: 1'b1, dir: DIR_RIGHT};
            SC_S:    m = '{hit: 1'b1, dir: DIR_DOWN};
            SC_A:    m = '{hit: 1'b1, dir: DIR_LEFT};
            default: m = '{hit: 1'b0, dir: DIR_UP};
        endcase
        return m;
    endfunction

    function automatic key_map_t decode_arrow(input logic [7:0] code);
        key_map_t m;
        case (code)
            SC_UP:    m = '{hit: 1'b1, dir: DIR_UP};
            SC_RIGHT: m = '{hit: 1'b1, dir: DIR_RIGHT};
            SC_DOWN:  m = '{hit: 1'b1, dir: DIR_DOWN};
            SC_LEFT:  m = '{hit: 1'b1, dir: DIR_LEFT};
            default:  m = '{hit: 1'b0, dir: DIR_UP};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_dir_arbiter.sv
// Per-player held-key tracker: keeps the held mask and last-pressed direction
// and produces a registered one-hot (or all-zero) direction.
module ps2_dir_arbiter
    import pacman_input_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       make,
    input  logic       brk,
    input  dir_t       dir,
    output logic [3:0] dir_oh
);

    logic [3:0] held_q, held_d;
    dir_t       last_q, last_d;
    logic [3:0] out_q,  out_d;

    // Clear is applied first so a key event in the same cycle still lands.
    always_comb begin
        held_d = clear ? 4'b0000 : held_q;
        last_d = clear ? DIR_UP  : last_q;
        if (make) begin
            held_d = held_d | dir_onehot(dir);
            last_d = dir;
        end else if (brk) begin
            held_d = held_d & ~dir_onehot(dir);
        end else begin
            held_d = held_d;
        end

        if ((held_d & dir_onehot(last_d)) != 4'b0000) begin
            out_d = dir_onehot(last_d);
        end else if (held_d[0]) begin
            out_d = 4'b0001;
        end else if (held_d[1]) begin
            out_d = 4'b0010;
        end else if (held_d[2]) begin
            out_d = 4'b0100;
        end else if (held_d[3]) begin
            out_d = 4'b1000;
        end else begin
            out_d = 4'b0000;
        end
    end

    // Held mask, last-pressed direction and output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            held_q <= 4'b0000;
            last_q <= DIR_UP;
            out_q  <= 4'b0000;
        end else begin
            held_q <= held_d;
            last_q <= last_d;
            out_q  <= out_d;
        end
    end

    assign dir_oh = out_q;

endmodule

// File: rtl/ps2_direction_decoder.sv
// PS/2 byte stream to per-player direction levels and a pause toggle.
// Optional build macro KEY_TIMEOUT_EN clears held keys after an idle period.
module ps2_direction_decoder
    import pacman_input_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
)(
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_key_pressed,
    input  logic [7:0] ps2_out,
    output logic       upSig,
    output logic       rightSig,
    output logic       downSig,
    output logic       leftSig,
    output logic       upSig2,
    output logic       rightSig2,
    output logic       downSig2,
    output logic       leftSig2,
    output logic       pauseButton
);

    ps2_state_e state_q, state_d, state_base_s;
    logic       pause_q, pause_d;
    logic       p_held_q, p_held_d, p_held_base_s;
    logic       make_s, brk_s, ext_s, p_hit_s;
    logic       timeout_s;
    key_map_t   wasd_s, arrow_s;
    logic [3:0] p0_oh_s, p1_oh_s;

`ifdef KEY_TIMEOUT_EN
    logic [31:0] idle_cnt_q, idle_cnt_d;

    // Idle counter restarts on every byte and saturates at the timeout.
    always_comb begin
        if (ps2_key_pressed) begin
            idle_cnt_d = 32'd0;
        end else if (idle_cnt_q < TIMEOUT_CYCLES) begin
            idle_cnt_d = idle_cnt_q + 32'd1;
        end else begin
            idle_cnt_d = idle_cnt_q;
        end
    end

    // Idle counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt_q <= 32'd0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign timeout_s = (idle_cnt_q == TIMEOUT_CYCLES);
`else
    // Timer compiled out; the parameter stays in the interface for both builds.
    assign timeout_s = (TIMEOUT_CYCLES == 32'd0) & 1'b0;
`endif

    // Prefix FSM: classify the byte as make/break, extended or not.
    always_comb begin
        state_base_s = timeout_s ? IDLE : state_q;
        state_d      = state_base_s;
        make_s       = 1'b0;
        brk_s        = 1'b0;
        ext_s        = 1'b0;
        if (ps2_key_pressed) begin
            case (state_base_s)
                IDLE: begin
                    if (ps2_out == SC_EXT) begin
                        state_d = EXT;
                    end else if (ps2_out == SC_BREAK) begin
                        state_d = BRK;
                    end else begin
                        make_s = 1'b1;
                    end
                end
                EXT: begin
                    if (ps2_out == SC_BREAK) begin
                        state_d = EXT_BRK;
                    end else begin
                        make_s  = 1'b1;
                        ext_s   = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    brk_s   = 1'b1;
                    state_d = IDLE;
                end
                EXT_BRK: begin
                    brk_s   = 1'b1;
                    ext_s   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_base_s;
        end
    end

    assign wasd_s  = decode_wasd(ps2_out);
    assign arrow_s = decode_arrow(ps2_out);
    assign p_hit_s = !ext_s && (ps2_out == SC_P);

    // Pause toggles only on a fresh P press; repeats are blocked by p_held.
    always_comb begin
        p_held_base_s = timeout_s ? 1'b0 : p_held_q;
        p_held_d      = p_held_base_s;
        pause_d       = pause_q;
        if (make_s && p_hit_s) begin
            if (!p_held_base_s) begin
                pause_d = ~pause_q;
            end else begin
                pause_d = pause_q;
            end
            p_held_d = 1'b1;
        end else if (brk_s && p_hit_s) begin
            p_held_d = 1'b0;
        end else begin
            p_held_d = p_held_base_s;
        end
    end

    // FSM state and pause registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            pause_q  <= 1'b0;
            p_held_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pause_q  <= pause_d;
            p_held_q <= p_held_d;
        end
    end

    ps2_dir_arbiter u_player0 (
        .clock  (clock),
        .reset  (reset),
        .clear  (timeout_s),
        .make   (make_s && !ext_s && wasd_s.hit),
        .brk    (brk_s && !ext_s && wasd_s.hit),
        .dir    (wasd_s.dir),
        .dir_oh (p0_oh_s)
    );

    ps2_dir_arbiter u_player1 (
        .clock  (clock),
        .reset  (reset),
        .clear  (timeout_s),
        .make   (make_s && ext_s && arrow_s.hit),
        .brk    (brk_s && ext_s && arrow_s.hit),
        .dir    (arrow_s.dir),
        .dir_oh (p1_oh_s)
    );

    assign upSig       = p0_oh_s[0];
    assign rightSig    = p0_oh_s[1];
    assign downSig     = p0_oh_s[2];
    assign leftSig     = p0_oh_s[3];
    assign upSig2      = p1_oh_s[0];
    assign rightSig2   = p1_oh_s[1];
    assign downSig2    = p1_oh_s[2];
    assign leftSig2    = p1_oh_s[3];
    assign pauseButton = pause_q;

endmodule
